// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED status-chain controller: channel mode
// encodings, serializer states and a small mode classification helper.
package led_ctrl_pkg;

  localparam int MODE_W = 4;

  typedef logic [MODE_W-1:0] mode_t;

  localparam mode_t LED_OFF    = 4'd0;
  localparam mode_t LED_ON     = 4'd1;
  localparam mode_t LED_SPARK  = 4'd2;
  localparam mode_t LED_SPARK1 = 4'd3;
  localparam mode_t LED_BLING  = 4'd4;

  typedef enum logic [1:0] {
    SH_IDLE,
    SH_SHIFT,
    SH_LATCH
  } shift_state_e;

  // Periodic modes keep their phase when the same mode is written again.
  function automatic logic is_periodic(input mode_t m);
    return (m == LED_SPARK1) || (m == LED_BLING);
  endfunction

endpackage

// File: rtl/led_shift_n.sv
// Serializer for a 74HC595-style chain: shifts WIDTH bits MSB first with
// DIV-cycle shift-clock half periods, then pulses the storage latch.
module led_shift_n
  import led_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             sft_shcp,
  output logic             sft_stcp,
  output logic             sft_ds
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  shift_state_e     state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] sr_shift;
  logic             shcp_q, shcp_d;
  logic             stcp_q, stcp_d;
  logic             ds_q, ds_d;

  assign sr_shift = sr_q << 1;

  // State and output registers; reset aborts any frame with all lines low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SH_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      shcp_q  <= 1'b0;
      stcp_q  <= 1'b0;
      ds_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      shcp_q  <= shcp_d;
      stcp_q  <= stcp_d;
      ds_q    <= ds_d;
    end
  end

  // Next-state logic; data only moves on the edge that drops the shift clock.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    shcp_d  = shcp_q;
    stcp_d  = stcp_q;
    ds_d    = ds_q;
    case (state_q)
      SH_IDLE: begin
        if (start) begin
          state_d = SH_SHIFT;
          sr_d    = din;
          ds_d    = din[WIDTH-1];
          div_d   = '0;
          bit_d   = '0;
          shcp_d  = 1'b0;
        end
      end
      SH_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!shcp_q) begin
            shcp_d = 1'b1;
          end else begin
            shcp_d = 1'b0;
            if (bit_q == BIT_LAST) begin
              state_d = SH_LATCH;
              stcp_d  = 1'b1;
              ds_d    = 1'b0;
            end else begin
              bit_d = bit_q + BIT_W'(1);
              sr_d  = sr_shift;
              ds_d  = sr_shift[WIDTH-1];
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      SH_LATCH: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          stcp_d  = 1'b0;
          state_d = SH_IDLE;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = SH_IDLE;
    endcase
  end

  assign busy     = (state_q != SH_IDLE);
  assign sft_shcp = shcp_q;
  assign sft_stcp = stcp_q;
  assign sft_ds   = ds_q;

endmodule

// File: rtl/led_ctrl_n.sv
// LED controller top: per-channel mode/counter logic, refresh coalescing
// through a single pending flag, and the serial chain driver.
module led_ctrl_n
  import led_ctrl_pkg::*;
#(
  parameter int CH        = 8,
  parameter int CNT_W     = 25,
  parameter int SPARK_MAX = 30000000,
  parameter int BLING_MAX = 8,
  parameter int SHIFT_DIV = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                vld,
  input  logic [4*CH-1:0]     reg_din,
  input  logic [CH-1:0]       led_tick,
  output logic                sft_shcp,
  output logic                sft_stcp,
  output logic                sft_ds,
  output logic                busy
);

  localparam logic [CNT_W-1:0] SPARK_CNT = CNT_W'(SPARK_MAX);
  localparam logic [CNT_W-1:0] BLING_CNT = CNT_W'(BLING_MAX);

  logic [CH-1:0] led_vec;
  logic [CH-1:0] expire_vec;
  logic          pending_q, pending_d;
  logic          request;
  logic          start;
  logic          shift_busy;

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    mode_t            mode_q, mode_d, mode_new;
    logic             led_q, led_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             expire;
    logic             load;

    assign mode_new = reg_din[MODE_W*gi +: MODE_W];
    assign load     = vld && !(is_periodic(mode_new) && (mode_new == mode_q));
    assign expire   = (((mode_q == LED_SPARK) || (mode_q == LED_SPARK1)) && (cnt_q == SPARK_CNT))
                   || ((mode_q == LED_BLING) && (cnt_q == BLING_CNT));

    // Channel registers.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        mode_q <= LED_OFF;
        led_q  <= 1'b0;
        cnt_q  <= '0;
      end else begin
        mode_q <= mode_d;
        led_q  <= led_d;
        cnt_q  <= cnt_d;
      end
    end

    // A new write wins over expiry; cnt==0 means the channel is not timing.
    always_comb begin
      mode_d = vld ? mode_new : mode_q;
      led_d  = led_q;
      cnt_d  = cnt_q;
      if (load) begin
        case (mode_new)
          LED_ON: begin
            led_d = 1'b1;
            cnt_d = '0;
          end
          LED_SPARK, LED_SPARK1, LED_BLING: begin
            led_d = 1'b1;
            cnt_d = CNT_W'(1);
          end
          default: begin
            led_d = 1'b0;
            cnt_d = '0;
          end
        endcase
      end else if (expire) begin
        if (mode_q == LED_SPARK) begin
          led_d = 1'b0;
          cnt_d = '0;
        end else begin
          led_d = ~led_q;
          cnt_d = CNT_W'(1);
        end
      end else if (cnt_q != '0) begin
        if (mode_q == LED_BLING) begin
          cnt_d = cnt_q + CNT_W'(led_tick[gi]);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    assign led_vec[gi]    = led_q;
    assign expire_vec[gi] = expire;
  end

  assign request = vld | (|expire_vec);
  assign start   = pending_q & ~shift_busy;

  // Requests arriving while a frame is shifting collapse into one follow-up.
  always_comb begin
    pending_d = request | (pending_q & ~start);
  end

  // Pending flag register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
    end
  end

  led_shift_n #(
    .WIDTH (CH),
    .DIV   (SHIFT_DIV)
  ) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .din      (led_vec),
    .busy     (shift_busy),
    .sft_shcp (sft_shcp),
    .sft_stcp (sft_stcp),
    .sft_ds   (sft_ds)
  );

  assign busy = shift_busy;

endmodule

// File: tb/tb_led_ctrl_n.sv
// Directed bench for led_ctrl_n: a timestamp-based channel model predicts
// each frame's contents, a line monitor captures frames off the serial pins.
module tb_led_ctrl_n;

  localparam int CH       = 8;
  localparam int DIV      = 2;
  localparam int SMAX     = 10;
  localparam int BMAX     = 8;
  localparam int BUSY_LEN = 2 * DIV * CH + DIV;

  logic          clk;
  logic          rst_n;
  logic          vld;
  logic [4*CH-1:0] reg_din;
  logic [CH-1:0] led_tick;
  logic          sft_shcp, sft_stcp, sft_ds, busy;

  int checks   = 0;
  int failures = 0;

  logic [CH-1:0] exp_q[$];
  logic [CH-1:0] got_q[$];
  logic [CH-1:0] last_frame;

  led_ctrl_n #(
    .CH        (CH),
    .CNT_W     (25),
    .SPARK_MAX (SMAX),
    .BLING_MAX (BMAX),
    .SHIFT_DIV (DIV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .vld      (vld),
    .reg_din  (reg_din),
    .led_tick (led_tick),
    .sft_shcp (sft_shcp),
    .sft_stcp (sft_stcp),
    .sft_ds   (sft_ds),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: deadlines in absolute cycles, tick countdown for bling.
  int            cyc;
  logic [3:0]    m_mode[CH];
  logic          m_led[CH];
  bit            m_act[CH];
  int            m_due[CH];
  int            m_left[CH];
  bit            m_pend;
  int            m_busy_left;

  initial begin
    logic [CH-1:0] old_led;
    logic [3:0]    nm;
    bit            req, per, st;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        for (int c = 0; c < CH; c++) begin
          m_mode[c] = 4'd0; m_led[c] = 1'b0; m_act[c] = 1'b0; m_due[c] = 0; m_left[c] = 0;
        end
        m_pend = 1'b0;
        m_busy_left = 0;
        exp_q.delete();
        cyc = 0;
      end else begin
        cyc++;
        for (int c = 0; c < CH; c++) old_led[c] = m_led[c];
        req = vld;
        for (int c = 0; c < CH; c++) begin
          nm  = reg_din[4*c +: 4];
          per = (nm == 4'd3) || (nm == 4'd4);
          if (vld && !(per && nm == m_mode[c])) begin
            m_act[c]  = (nm >= 4'd2) && (nm <= 4'd4);
            m_led[c]  = (nm >= 4'd1) && (nm <= 4'd4);
            m_due[c]  = cyc + SMAX;
            m_left[c] = BMAX - 1;
          end else if (m_act[c]) begin
            if (m_mode[c] == 4'd4) begin
              if (m_left[c] == 0) begin
                m_led[c]  = ~m_led[c];
                m_left[c] = BMAX - 1;
                req = 1'b1;
              end else if (led_tick[c]) begin
                m_left[c]--;
              end
            end else if (cyc == m_due[c]) begin
              req = 1'b1;
              if (m_mode[c] == 4'd2) begin
                m_led[c] = 1'b0;
                m_act[c] = 1'b0;
              end else begin
                m_led[c] = ~m_led[c];
                m_due[c] = cyc + SMAX;
              end
            end
          end
          if (vld) m_mode[c] = nm;
        end
        st = m_pend && (m_busy_left == 0);
        if (st) begin
          exp_q.push_back(old_led);
          m_busy_left = BUSY_LEN;
        end else if (m_busy_left > 0) begin
          m_busy_left--;
        end
        m_pend = req || (m_pend && !st);
      end
    end
  end

  // Pin monitor: rebuilds frames, pulse widths, gaps and protocol violations.
  logic [CH-1:0] mon_sr;
  int mon_bits, last_bits, stcp_cnt, last_stcp_w, busy_cnt, last_busy_len;
  int idle_cnt, last_gap, latch_total, viol;
  logic shcp_prev, stcp_prev, ds_prev, busy_prev;

  initial begin
    mon_sr = '0; mon_bits = 0; last_bits = 0; stcp_cnt = 0; last_stcp_w = 0;
    busy_cnt = 0; last_busy_len = 0; idle_cnt = 0; last_gap = 0; latch_total = 0; viol = 0;
    shcp_prev = 1'b0; stcp_prev = 1'b0; ds_prev = 1'b0; busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_sr = '0; mon_bits = 0; stcp_cnt = 0; busy_cnt = 0; idle_cnt = 0;
      end else begin
        if (sft_shcp && !shcp_prev) begin
          mon_sr = {mon_sr[CH-2:0], sft_ds};
          mon_bits++;
        end
        if (sft_shcp && shcp_prev && (sft_ds !== ds_prev)) viol++;
        if (sft_stcp && sft_shcp) viol++;
        if (sft_stcp && !stcp_prev) begin
          got_q.push_back(mon_sr);
          last_bits = mon_bits;
          mon_bits = 0;
          latch_total++;
        end
        if (sft_stcp) stcp_cnt++;
        else if (stcp_prev) begin
          last_stcp_w = stcp_cnt;
          stcp_cnt = 0;
        end
        if (busy) begin
          if (!busy_prev) last_gap = idle_cnt;
          busy_cnt++;
          idle_cnt = 0;
        end else begin
          if (busy_prev) begin
            last_busy_len = busy_cnt;
            busy_cnt = 0;
          end
          idle_cnt++;
        end
      end
      shcp_prev = sft_shcp; stcp_prev = sft_stcp; ds_prev = sft_ds; busy_prev = busy;
    end
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic pop_one(input string tag);
    logic [CH-1:0] g;
    g = got_q.pop_front();
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected_frame"}, exp_q.size(), 1);
    end else begin
      check(tag, g, exp_q.pop_front());
    end
    last_frame = g;
  endtask

  task automatic pop_frames(input string tag);
    while (got_q.size() > 0) pop_one(tag);
  endtask

  task automatic run(input int n, input string tag);
    repeat (n) begin
      @(negedge clk);
      pop_frames(tag);
    end
  endtask

  task automatic next_frame(input string tag);
    int k = 0;
    while (got_q.size() == 0 && k < 600) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_arrived"}, (got_q.size() > 0), 1);
    if (got_q.size() > 0) pop_one(tag);
  endtask

  task automatic drain(input string tag);
    int k = 0;
    int quiet = 0;
    while (quiet < 4 && k < 2000) begin
      @(negedge clk);
      k++;
      pop_frames(tag);
      if (!busy && got_q.size() == 0) quiet++;
      else quiet = 0;
    end
    check({tag, "_frames_left"}, exp_q.size(), 0);
  endtask

  task automatic write_din(input logic [31:0] d);
    @(negedge clk);
    vld = 1'b1;
    reg_din = d;
    @(negedge clk);
    vld = 1'b0;
  endtask

  initial begin
    int lat0;
    rst_n = 1'b0; vld = 1'b0; reg_din = '0; led_tick = '0;
    repeat (4) @(negedge clk);
    check("rst_shcp", sft_shcp, 0);
    check("rst_stcp", sft_stcp, 0);
    check("rst_ds", sft_ds, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;

    // 1: all channels ON, latency and frame shape
    @(negedge clk); vld = 1'b1; reg_din = 32'h1111_1111;
    @(negedge clk); vld = 1'b0;
    check("t1_busy_before_snapshot", busy, 0);
    @(negedge clk);
    check("t1_busy_latency", busy, 1);
    check("t1_first_bit", sft_ds, 1);
    next_frame("t1_frame");
    check("t1_frame_value", last_frame, 8'hFF);
    drain("t1");
    check("t1_busy_len", last_busy_len, BUSY_LEN);
    check("t1_stcp_width", last_stcp_w, DIV);
    check("t1_bits", last_bits, CH);

    // 2: one-shot spark on ch0 gives an on frame then an off frame
    write_din(32'h0000_0002);
    next_frame("t2_on");
    check("t2_on_value", last_frame, 8'h01);
    next_frame("t2_off");
    check("t2_off_value", last_frame, 8'h00);
    lat0 = latch_total;
    run(150, "t2_quiet");
    check("t2_no_more_frames", latch_total, lat0);
    drain("t2");

    // 3: SPARK1 on ch1, same-mode rewrite mid-period, BLING then SPARK1 restart
    write_din(32'h0000_0030);
    run(25, "t3_a");
    write_din(32'h0000_0030);
    run(60, "t3_b");
    write_din(32'h0000_0040);
    run(15, "t3_c");
    write_din(32'h0000_0030);
    run(80, "t3_d");
    write_din(32'h0000_0000);
    drain("t3");

    // 4: BLING on ch2 with a tick every third cycle
    write_din(32'h0000_0400);
    for (int k = 0; k < 90; k++) begin
      @(negedge clk);
      led_tick = (k % 3 == 0) ? 8'h04 : 8'h00;
      pop_frames("t4");
    end
    led_tick = '0;
    write_din(32'h0000_0000);
    drain("t4");

    // 5: two writes during a busy frame coalesce into one follow-up frame
    lat0 = latch_total;
    write_din(32'h0000_0001);
    run(5, "t5_a");
    write_din(32'h0000_1000);
    run(5, "t5_b");
    write_din(32'h0000_0000);
    next_frame("t5_first");
    check("t5_first_value", last_frame, 8'h01);
    next_frame("t5_second");
    check("t5_second_value", last_frame, 8'h00);
    drain("t5");
    check("t5_frame_count", latch_total - lat0, 2);
    check("t5_idle_gap", last_gap, 1);

    // 6: reserved mode 0xF acts as OFF, then reset mid-shift
    write_din(32'h1111_1111);
    drain("t6_a");
    write_din(32'hF1F1_F1F1);
    next_frame("t6_reserved");
    check("t6_reserved_value", last_frame, 8'h55);
    drain("t6_b");
    write_din(32'h1111_1111);
    run(10, "t6_c");
    check("t6_busy_mid_shift", busy, 1);
    lat0 = latch_total;
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_rst_shcp", sft_shcp, 0);
    check("t6_rst_stcp", sft_stcp, 0);
    check("t6_rst_ds", sft_ds, 0);
    check("t6_rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run(80, "t6_after");
    check("t6_no_latch_after_abort", latch_total, lat0);
    check("t6_frames_left", exp_q.size(), 0);
    check("protocol_violations", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_ctrl_n.md
# led_ctrl_n

Parametrised successor LED controller for the board status chain. It drives CH LEDs through an external serial-in/parallel-out shift register (74HC595 style: shift clock, storage latch, data). Each channel has its own 4-bit mode: off, on, one-shot spark, periodic spark, or tick-gated bling. Refresh requests that arrive while a frame is shifting are coalesced into one follow-up frame, and every frame ends with an explicit latch pulse.

## Interface
Parameters:
- CH, 8: number of LED channels (1..32).
- CNT_W, 25: per-channel counter width.
- SPARK_MAX, 30000000: spark period in clk cycles (300 ms at 100 MHz); must fit CNT_W.
- BLING_MAX, 8: bling period in led_tick pulses; must fit CNT_W.
- SHIFT_DIV, 4: clk cycles per shift-clock half period (≥1).

Ports:
- clk, input, 1: sole clock.
- rst_n, input, 1: reset, synchronous, active-low.
- vld, input, 1: one-cycle strobe; reg_din is sampled on this cycle.
- reg_din, input, 4*CH: channel i mode in bits [4i+3:4i].
- led_tick, input, CH: per-channel advance enable, used only in BLING mode.
- sft_shcp, output, 1: shift-register clock.
- sft_stcp, output, 1: storage-latch clock.
- sft_ds, output, 1: serial data.
- busy, output, 1: frame in progress.

## Operation
- Modes:
  - 0 OFF.
  - 1 ON.
  - 2 SPARK: one-shot pulse.
  - 3 SPARK1: periodic toggle.
  - 4 BLING: periodic toggle, tick-gated.
  - 5–15 reserved; treated exactly as OFF.
- Per channel the block keeps mode_q, led_q and cnt (CNT_W bits).
- On vld, mode_q is loaded with reg_din, and the new mode acts as follows:
  - OFF, reserved: led_q=0, cnt=0.
  - ON: led_q=1, cnt=0.
  - SPARK: led_q=1, cnt=1.
  - SPARK1/BLING with a mode different from old mode_q: led_q=1, cnt=1.
  - SPARK1/BLING with the same mode: no change (phase preserved).
- Expiry occurs when cnt==SPARK_MAX (SPARK, SPARK1) or cnt==BLING_MAX (BLING):
  - SPARK: led_q=0, cnt=0.
  - SPARK1/BLING: led_q toggles, cnt=1.
- Otherwise, when cnt≠0, cnt increments by 1 (SPARK, SPARK1) or by led_tick[i] (BLING).
- vld has priority over expiry in the same cycle.
- Refresh request = vld OR any expiry. It sets `pending`.
- Serializer sub-block, states IDLE → SHIFT → LATCH → IDLE:
  - IDLE, pending=1: snapshot led_q, clear pending. If a new request arrives on the same cycle, pending stays set.
  - SHIFT: CH bits, channel CH-1 first, channel 0 last. Per bit: sft_ds stable; sft_shcp low for SHIFT_DIV cycles, then high for SHIFT_DIV cycles.
  - LATCH: sft_stcp high for SHIFT_DIV cycles, sft_shcp low.
- Any number of requests during a frame produce exactly one further frame, built from the latest led_q.

## Timing
- Reset values: sft_shcp=0, sft_stcp=0, sft_ds=0, busy=0; all led_q, cnt, mode_q, pending = 0.
- Reset mid-frame aborts the frame: outputs are 0 after the reset edge and no latch pulse is issued.
- Latency:
  - vld sampled at edge E0; led_q and pending valid after E0.
  - Snapshot at E1; busy=1 and the first sft_ds bit valid after E1.
- busy stays high for 2·SHIFT_DIV·CH + SHIFT_DIV cycles. It drops to 0 for at least one cycle between back-to-back frames.
- SPARK on-time: SPARK_MAX−1 cycles from load to the expiry cycle; led_q=0 after the following edge.
- sft_ds changes only while sft_shcp=0. sft_stcp never overlaps sft_shcp high.

## Structure
- Package led_ctrl_pkg:
  - Mode constants LED_OFF, LED_ON, LED_SPARK, LED_SPARK1, LED_BLING.
  - Mode width 4.
- Sub-module led_shift_n (params WIDTH=CH, DIV=SHIFT_DIV):
  - Inputs: clk, rst_n, start, din[WIDTH-1:0].
  - Outputs: busy, sft_shcp, sft_stcp, sft_ds.
  - Contains the serializer FSM and the divide counter.
- Top level holds the per-channel logic in a generate loop over CH, plus pending and the expiry OR-reduce.

## Test plan
Bench parameters: CH=8, SHIFT_DIV=2, SPARK_MAX=10, BLING_MAX=8.
1. Reset, then vld with reg_din=0x11111111 → frame of 8 ones, one 2-cycle sft_stcp pulse, busy high for 34 cycles, vld-to-busy latency 1 cycle.
2. vld with ch0=SPARK, others OFF → frame with bit0=1. ch0 expires 9 cycles after load, producing a second frame of all zeros; no further frames.
3. ch1=SPARK1, then the same SPARK1 written again mid-period → toggle times unchanged. Writing BLING then SPARK1 → counter restarts, led1=1.
4. ch2=BLING with led_tick[2] pulsing every 3 cycles → toggle after the 7th tick (cnt 1→8), repeating every 7 ticks.
5. Two vlds during a busy frame (ch3 ON, then ch3 OFF) → exactly one extra frame, starting one idle cycle after LATCH, carrying ch3=0.
6. rst_n low mid-SHIFT → outputs 0 next edge, no sft_stcp pulse. A mode of 0xF behaves as OFF.
